// File: rtl/audio_sample_player.sv
// Sound-effect player: fetches a {start, length} descriptor, streams sample bytes
// at a fixed rate, and converts the current level into a free-running 8-bit PWM.
module audio_sample_player #(
  parameter int SAMPLE_BITS = 4,
  parameter int ADDR_BITS   = 14,
  parameter int CLK_DIV     = 6250,
  parameter int DIV_BITS    = 13,
  parameter int IDLE_LEVEL  = 128
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [SAMPLE_BITS-1:0] AUDIO_SELECT,
  input  logic                   AUDIO_TRIGGER,
  output logic [SAMPLE_BITS-1:0] DESC_SEL,
  input  logic [ADDR_BITS-1:0]   DESC_START,
  input  logic [ADDR_BITS-1:0]   DESC_LEN,
  output logic [ADDR_BITS-1:0]   SAMPLE_ADDR,
  input  logic [7:0]             SAMPLE_DATA,
  output logic [7:0]             LEVEL,
  output logic                   PLAYING,
  output logic                   PWM_OUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DESC_WAIT,
    S_DESC_LOAD,
    S_PLAY
  } state_e;

  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);
  localparam logic [7:0]          IDLE_LVL = 8'(IDLE_LEVEL);

  state_e                 state_q,       state_d;
  logic [SAMPLE_BITS-1:0] desc_sel_q,    desc_sel_d;
  logic [ADDR_BITS-1:0]   sample_addr_q, sample_addr_d;
  logic [ADDR_BITS-1:0]   remaining_q,   remaining_d;
  logic [DIV_BITS-1:0]    div_q,         div_d;
  logic [7:0]             level_q,       level_d;
  logic                   playing_q,     playing_d;
  logic [7:0]             pwm_cnt_q,     pwm_cnt_d;
  logic                   pwm_out_q,     pwm_out_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    desc_sel_d    = desc_sel_q;
    sample_addr_d = sample_addr_q;
    remaining_d   = remaining_q;
    div_d         = div_q;
    level_d       = level_q;
    playing_d     = playing_q;
    pwm_cnt_d     = pwm_cnt_q + 8'd1;
    pwm_out_d     = (pwm_cnt_q < level_q);

    // A trigger pre-empts whatever the FSM would have done on this edge.
    if (AUDIO_TRIGGER) begin
      desc_sel_d = AUDIO_SELECT;
      state_d    = S_DESC_WAIT;
      playing_d  = 1'b0;
    end else begin
      case (state_q)
        S_DESC_WAIT: state_d = S_DESC_LOAD;
        S_DESC_LOAD: begin
          if (DESC_LEN == '0) begin
            state_d = S_IDLE;
            level_d = IDLE_LVL;
          end else begin
            state_d       = S_PLAY;
            sample_addr_d = DESC_START;
            remaining_d   = DESC_LEN;
            div_d         = '0;
            playing_d     = 1'b1;
          end
        end
        S_PLAY: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (remaining_q != '0) begin
              level_d       = SAMPLE_DATA;
              sample_addr_d = sample_addr_q + ADDR_BITS'(1);
              remaining_d   = remaining_q - ADDR_BITS'(1);
            end else begin
              level_d   = IDLE_LVL;
              playing_d = 1'b0;
              state_d   = S_IDLE;
            end
          end else begin
            div_d = div_q + DIV_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      desc_sel_q    <= '0;
      sample_addr_q <= '0;
      remaining_q   <= '0;
      div_q         <= '0;
      level_q       <= IDLE_LVL;
      playing_q     <= 1'b0;
      pwm_cnt_q     <= '0;
      pwm_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      desc_sel_q    <= desc_sel_d;
      sample_addr_q <= sample_addr_d;
      remaining_q   <= remaining_d;
      div_q         <= div_d;
      level_q       <= level_d;
      playing_q     <= playing_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pwm_out_q     <= pwm_out_d;
    end
  end

  assign DESC_SEL    = desc_sel_q;
  assign SAMPLE_ADDR = sample_addr_q;
  assign LEVEL       = level_q;
  assign PLAYING     = playing_q;
  assign PWM_OUT     = pwm_out_q;

endmodule
